// File: rtl/gcd_req_feeder.sv
// Operand-pair FIFO in front of a GCD unit: queues {B,A} pairs and issues
// them one at a time, tracking the single outstanding request.
module gcd_req_feeder #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    output logic [2*W-1:0]         req_msg,
    output logic                   req_val,
    input  logic                   req_rdy,
    input  logic                   resp_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic [7:0]             issued,
    output logic                   err_spur
);
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("gcd_req_feeder: DEPTH must be a power of two in 2..16");
    end

    logic [2*W-1:0] r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           r_busy;
    logic           r_err;
    logic [7:0]     r_issued;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);
    // Full blocks a push even when a pop happens on the same edge.
    assign w_push  = in_val && !w_full;
    assign w_pop   = !w_empty && !r_busy && req_rdy;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_b, in_a};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An issue on the same edge as resp_done wins: that resp_done is spurious.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_issued <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_busy   <= 1'b1;
                r_issued <= r_issued + 8'd1;
            end else if (resp_done) begin
                r_busy <= 1'b0;
            end
            if (resp_done && !r_busy) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_rdy   = !w_full;
    assign req_val  = !w_empty && !r_busy;
    assign req_msg  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count    = r_count;
    assign busy     = r_busy;
    assign issued   = r_issued;
    assign err_spur = r_err;
endmodule
